load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 186 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns one load or store request into one or two 32-bit bus beats,
// checks alignment, and sign/zero-extends load data to 64 bits.
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  mem_ctrl,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [63:0] rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [63:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BEAT0 = 2'd1;
    localparam logic [1:0] S_BEAT1 = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [2:0] C_NONE  = 3'd0;
    localparam logic [2:0] C_B     = 3'd1;
    localparam logic [2:0] C_H     = 3'd2;
    localparam logic [2:0] C_W     = 3'd3;
    localparam logic [2:0] C_D     = 3'd4;
    localparam logic [2:0] C_BU    = 3'd5;
    localparam logic [2:0] C_HU    = 3'd6;
    localparam logic [2:0] C_WU    = 3'd7;

    logic [1:0]  state_q, state_d;
    logic        store_q, store_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] whi_q, whi_d;
    logic [31:0] lo_q, lo_d;
    logic        fault_q, fault_d;
    logic [63:0] rdata_q, rdata_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [63:0] baddr_q, baddr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] bwd_q, bwd_d;

    logic        misaligned;
    logic [3:0]  be_new;
    logic [31:0] wd_new;

    always_comb begin
        misaligned = 1'b0;
        be_new     = 4'b1111;
        wd_new     = wdata[31:0];
        case (mem_ctrl)
            C_B, C_BU: begin
                be_new = 4'(4'b0001 << addr[1:0]);
                wd_new = {4{wdata[7:0]}};
            end
            C_H, C_HU: begin
                misaligned = addr[0];
                be_new     = 4'(4'b0011 << addr[1:0]);
                wd_new     = {2{wdata[15:0]}};
            end
            C_W, C_WU: misaligned = |addr[1:0];
            C_D:       misaligned = |addr[2:0];
            default: ;
        endcase
    end

    // Lane select then extend; DWORD is assembled separately from both beats.
    function automatic logic [63:0] extract(input logic [2:0] c, input logic [1:0] lane,
                                            input logic [31:0] d);
        logic [31:0] sh;
        sh = d >> {lane, 3'b000};
        case (c)
            C_B:     extract = {{56{sh[7]}}, sh[7:0]};
            C_BU:    extract = {56'd0, sh[7:0]};
            C_H:     extract = {{48{sh[15]}}, sh[15:0]};
            C_HU:    extract = {48'd0, sh[15:0]};
            C_W:     extract = {{32{sh[31]}}, sh};
            default: extract = {32'd0, sh};
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        store_d = store_q;
        ctrl_d  = ctrl_q;
        lane_d  = lane_q;
        whi_d   = whi_q;
        lo_d    = lo_q;
        fault_d = 1'b0;
        rdata_d = rdata_q;
        req_d   = req_q;
        we_d    = we_q;
        baddr_d = baddr_q;
        be_d    = be_q;
        bwd_d   = bwd_q;
        case (state_q)
            S_IDLE: if (start) begin
                store_d = is_store;
                ctrl_d  = mem_ctrl;
                lane_d  = addr[1:0];
                whi_d   = wdata[63:32];
                if (mem_ctrl == C_NONE || misaligned) begin
                    state_d = S_DONE;
                    fault_d = misaligned;
                end else begin
                    state_d = S_BEAT0;
                    req_d   = 1'b1;
                    we_d    = is_store;
                    baddr_d = {addr[63:2], 2'b00};
                    be_d    = be_new;
                    bwd_d   = wd_new;
                end
            end
            S_BEAT0: if (bus_ack) begin
                if (ctrl_q == C_D) begin
                    state_d = S_BEAT1;
                    lo_d    = bus_rdata;
                    baddr_d = baddr_q + 64'd4;
                    bwd_d   = whi_q;
                end else begin
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    if (!store_q) rdata_d = extract(ctrl_q, lane_q, bus_rdata);
                end
            end
            S_BEAT1: if (bus_ack) begin
                state_d = S_DONE;
                req_d   = 1'b0;
                if (!store_q) rdata_d = {bus_rdata, lo_q};
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            store_q <= 1'b0;
            ctrl_q  <= C_NONE;
            lane_q  <= 2'd0;
            whi_q   <= 32'd0;
            lo_q    <= 32'd0;
            fault_q <= 1'b0;
            rdata_q <= 64'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            baddr_q <= 64'd0;
            be_q    <= 4'd0;
            bwd_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            store_q <= store_d;
            ctrl_q  <= ctrl_d;
            lane_q  <= lane_d;
            whi_q   <= whi_d;
            lo_q    <= lo_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
            req_q   <= req_d;
            we_q    <= we_d;
            baddr_q <= baddr_d;
            be_q    <= be_d;
            bwd_q   <= bwd_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign fault     = fault_q;
    assign rdata     = rdata_q;
    assign bus_req   = req_q;
    assign bus_we    = we_q;
    assign bus_addr  = baddr_q;
    assign bus_be    = be_q;
    assign bus_wdata = bwd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: inputs driven and outputs sampled on the falling edge.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  mem_ctrl = 3'd0;
    logic [63:0] addr = 64'd0;
    logic [63:0] wdata = 64'd0;
    logic        busy, done, fault;
    logic [63:0] rdata;
    logic        bus_req, bus_we;
    logic [63:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = 32'd0;
    logic        bus_ack = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
        .mem_ctrl(mem_ctrl), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .fault(fault), .rdata(rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Present a request for one cycle, then scramble the inputs to prove they were captured.
    task automatic issue(input logic st, input logic [2:0] c, input logic [63:0] a,
                         input logic [63:0] wd);
        start = 1'b1; is_store = st; mem_ctrl = c; addr = a; wdata = wd;
        @(negedge clk);
        start = 1'b0; is_store = ~st; mem_ctrl = 3'd0; addr = '1; wdata = 64'd0;
    endtask

    // Zero-wait single-beat access with full bus and result checks.
    task automatic single(input string tag, input logic st, input logic [2:0] c,
                          input logic [63:0] a, input logic [63:0] wd,
                          input logic [31:0] rd, input logic [3:0] ebe,
                          input logic [31:0] ewd, input logic [63:0] erd);
        issue(st, c, a, wd);
        chk({tag, ".req"}, 64'(bus_req), 64'd1);
        chk({tag, ".we"}, 64'(bus_we), 64'(st));
        chk({tag, ".addr"}, bus_addr, {a[63:2], 2'b00});
        chk({tag, ".be"}, 64'(bus_be), 64'(ebe));
        if (st) chk({tag, ".wd"}, 64'(bus_wdata), 64'(ewd));
        chk({tag, ".done0"}, 64'(done), 64'd0);
        bus_ack = 1'b1; bus_rdata = rd;
        @(negedge clk);
        bus_ack = 1'b0; bus_rdata = 32'd0;
        chk({tag, ".done"}, 64'(done), 64'd1);
        chk({tag, ".fault"}, 64'(fault), 64'd0);
        chk({tag, ".reqoff"}, 64'(bus_req), 64'd0);
        chk({tag, ".rdata"}, rdata, erd);
        @(negedge clk);
        chk({tag, ".idle"}, {62'd0, busy, done}, 64'd0);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst.ctl", {59'd0, busy, done, fault, bus_req, bus_we}, 64'd0);
        chk("rst.rdata", rdata, 64'd0);
        chk("rst.addr", bus_addr, 64'd0);
        chk("rst.be_wd", {28'd0, bus_be, bus_wdata}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        single("LB",  1'b0, 3'd1, 64'h1003, 64'd0, 32'h80FFFFFF, 4'b1000, 32'd0, 64'hFFFFFFFFFFFFFF80);
        single("LBU", 1'b0, 3'd5, 64'h1003, 64'd0, 32'h80FFFFFF, 4'b1000, 32'd0, 64'h0000000000000080);
        single("LH",  1'b0, 3'd2, 64'h0010, 64'd0, 32'h00008001, 4'b0011, 32'd0, 64'hFFFFFFFFFFFF8001);
        single("LHU", 1'b0, 3'd6, 64'h0012, 64'd0, 32'hF00D1234, 4'b1100, 32'd0, 64'h000000000000F00D);
        single("LW",  1'b0, 3'd3, 64'h0020, 64'd0, 32'h80000000, 4'b1111, 32'd0, 64'hFFFFFFFF80000000);
        single("LWU", 1'b0, 3'd7, 64'h0024, 64'd0, 32'h80000000, 4'b1111, 32'd0, 64'h0000000080000000);
        single("SB",  1'b1, 3'd1, 64'h0031, 64'h123456789ABCDE5A, 32'hFFFFFFFF, 4'b0010, 32'h5A5A5A5A,
               64'h0000000080000000);

        // Halfword store with one wait state: request must hold steady
        issue(1'b1, 3'd2, 64'h2002, 64'hDEADDEADDEADBEEF);
        chk("SH.we", 64'(bus_we), 64'd1);
        chk("SH.addr", bus_addr, 64'h2000);
        chk("SH.be", 64'(bus_be), 64'hC);
        chk("SH.wd", 64'(bus_wdata), 64'hBEEFBEEF);
        @(negedge clk);
        chk("SH.hold", {bus_req, bus_we, bus_be, bus_wdata, bus_addr[15:0]}, {1'b1, 1'b1, 4'hC, 32'hBEEFBEEF, 16'h2000});
        chk("SH.nodone", 64'(done), 64'd0);
        bus_ack = 1'b1; bus_rdata = 32'h55555555;
        @(negedge clk); bus_ack = 1'b0;
        chk("SH.done", 64'(done), 64'd1);
        chk("SH.rhold", rdata, 64'h0000000080000000);
        @(negedge clk);

        // DWORD load, two wait states on beat 0; done at start+5
        issue(1'b0, 3'd4, 64'h3000, 64'd0);
        chk("LD.a0", bus_addr, 64'h3000);
        chk("LD.be", 64'(bus_be), 64'hF);
        @(negedge clk);
        chk("LD.w1", {62'd0, bus_req, done}, 64'd2);
        @(negedge clk);
        chk("LD.w2", bus_addr, 64'h3000);
        bus_ack = 1'b1; bus_rdata = 32'h11111111;
        @(negedge clk);
        chk("LD.a1", bus_addr, 64'h3004);
        chk("LD.b1done", 64'(done), 64'd0);
        bus_rdata = 32'h22222222;
        @(negedge clk); bus_ack = 1'b0; bus_rdata = 32'd0;
        chk("LD.done", 64'(done), 64'd1);
        chk("LD.rdata", rdata, 64'h2222222211111111);
        @(negedge clk);

        // DWORD store: upper word goes out on beat 1
        issue(1'b1, 3'd4, 64'h5000, 64'hAABBCCDD11223344);
        chk("SD.wd0", 64'(bus_wdata), 64'h11223344);
        bus_ack = 1'b1;
        @(negedge clk);
        chk("SD.wd1", {bus_addr[31:0], bus_wdata}, 64'h00005004AABBCCDD);
        @(negedge clk); bus_ack = 1'b0;
        chk("SD.done", {62'd0, done, fault}, 64'd2);
        chk("SD.rhold", rdata, 64'h2222222211111111);
        @(negedge clk);

        // Misaligned word: no bus, fault with done at start+1
        issue(1'b0, 3'd3, 64'h4002, 64'd0);
        chk("MIS.req", 64'(bus_req), 64'd0);
        chk("MIS.df", {62'd0, done, fault}, 64'd3);
        chk("MIS.rdata", rdata, 64'h2222222211111111);
        @(negedge clk);
        chk("MIS.clr", {61'd0, busy, done, fault}, 64'd0);

        // Misaligned DWORD on a word boundary
        issue(1'b0, 3'd4, 64'h3004, 64'd0);
        chk("MISD.df", {61'd0, bus_req, done, fault}, 64'd3);
        @(negedge clk);

        // mem_ctrl none: done without fault or bus activity
        issue(1'b0, 3'd0, 64'h4002, 64'd0);
        chk("NONE.df", {61'd0, bus_req, done, fault}, 64'd2);
        @(negedge clk);

        // Reset while in BEAT0
        issue(1'b0, 3'd3, 64'h6000, 64'd0);
        chk("RST.req", 64'(bus_req), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk("RST.clr", {61'd0, busy, bus_req, done}, 64'd0);
        chk("RST.addr", bus_addr, 64'd0);
        chk("RST.rdata", rdata, 64'd0);
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF; rst_n = 1'b1;
        @(negedge clk);
        chk("RST.ign", {61'd0, busy, bus_req, done}, 64'd0);
        @(negedge clk);
        chk("RST.ign2", {62'd0, done, busy}, 64'd0);
        bus_ack = 1'b0;
        single("POST", 1'b0, 3'd5, 64'h7001, 64'd0, 32'h0000A500, 4'b0010, 32'd0, 64'h00000000000000A5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
